// File: rtl/fc_bit_streamer_if.sv
// fc_bit_streamer_if: activation, weight-ROM and bit-stream signals of the FC bit streamer.
interface fc_bit_streamer_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] w_base;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_addr;
    logic [WORD_W-1:0] w_data;
    logic              ivalid;
    logic              inputdata;
    logic              weight;
    logic              busy;
    logic              done;
    modport master (
        input  start, w_base, in_valid, in_data, w_data,
        output in_ready, w_rd_en, w_addr, ivalid, inputdata, weight, busy, done
    );
    modport slave (
        output start, w_base, in_valid, in_data, w_data,
        input  in_ready, w_rd_en, w_addr, ivalid, inputdata, weight, busy, done
    );
endinterface

// File: rtl/fc_bit_streamer.sv
// fc_bit_streamer: serialises activation words and their ROM weights into the 1-bit FC stream.
module fc_bit_streamer #(
    parameter int N_BITS = 576,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 10
) (
    input logic               clk,
    input logic               rst,
    fc_bit_streamer_if.master bus
);
    localparam int N_WORDS = N_BITS / WORD_W;
    localparam int CNT_W = $clog2(WORD_W);
    localparam int IDX_W = N_WORDS > 1 ? $clog2(N_WORDS) : 1;
    localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, STREAM = 2'd2, DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] data_sr_q, data_sr_d;
    logic [WORD_W-1:0] w_sr_q, w_sr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic              ivalid_q, ivalid_d;
    logic              inputdata_q, inputdata_d;
    logic              weight_q, weight_d;
    logic              first_q, first_d;
    logic              accept, last_bit, last_word;

    assign accept    = state_q == FETCH && bus.in_valid;
    assign last_bit  = bit_cnt_q == CNT_W'(WORD_W - 1);
    assign last_word = word_idx_q == IDX_W'(N_WORDS - 1);

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        bit_cnt_d   = bit_cnt_q;
        data_sr_d   = data_sr_q;
        w_addr_d    = w_addr_q;
        ivalid_d    = 1'b0;
        inputdata_d = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d    = FETCH;
                word_idx_d = '0;
                w_addr_d   = bus.w_base;
            end
            FETCH: if (bus.in_valid) begin
                state_d     = STREAM;
                bit_cnt_d   = '0;
                data_sr_d   = bus.in_data >> 1;
                ivalid_d    = 1'b1;
                inputdata_d = bus.in_data[0];
            end
            STREAM: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d    = last_word ? DONE : FETCH;
                    word_idx_d = last_word ? word_idx_q : word_idx_q + IDX_W'(1);
                    w_addr_d   = last_word ? w_addr_q : w_addr_q + ADDR_W'(1);
                end else begin
                    ivalid_d    = 1'b1;
                    inputdata_d = data_sr_q[0];
                    data_sr_d   = data_sr_q >> 1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ROM data arrives in the first STREAM cycle, so weights trail the activation bits by one cycle
    always_comb begin
        first_d  = accept;
        weight_d = first_q ? bus.w_data[0] : state_q == STREAM ? w_sr_q[0] : weight_q;
        w_sr_d   = first_q ? bus.w_data >> 1 : state_q == STREAM ? w_sr_q >> 1 : w_sr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_idx_q  <= '0;
            bit_cnt_q   <= '0;
            data_sr_q   <= '0;
            w_sr_q      <= '0;
            w_addr_q    <= '0;
            ivalid_q    <= 1'b0;
            inputdata_q <= 1'b0;
            weight_q    <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            data_sr_q   <= data_sr_d;
            w_sr_q      <= w_sr_d;
            w_addr_q    <= w_addr_d;
            ivalid_q    <= ivalid_d;
            inputdata_q <= inputdata_d;
            weight_q    <= weight_d;
            first_q     <= first_d;
        end
    end

    assign bus.in_ready  = state_q == FETCH;
    assign bus.w_rd_en   = accept;
    assign bus.w_addr    = w_addr_q;
    assign bus.ivalid    = ivalid_q;
    assign bus.inputdata = inputdata_q;
    assign bus.weight    = weight_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
endmodule

// File: tb/tb_fc_bit_streamer.sv
// tb_fc_bit_streamer: frame-level reference checks of the FC bit streamer against a ROM model.
module tb_fc_bit_streamer;
    localparam int N_BITS = 576, WORD_W = 16, ADDR_W = 10, N_WORDS = N_BITS / WORD_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [WORD_W-1:0] rom [1 << ADDR_W];
    logic [WORD_W-1:0] act [N_WORDS];

    fc_bit_streamer_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();
    fc_bit_streamer #(.N_BITS(N_BITS), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) if (bus.w_rd_en) bus.w_data <= rom[bus.w_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle();
        chk("idle_ivalid", bus.ivalid, 0);
        chk("idle_inputdata", bus.inputdata, 0);
        chk("idle_weight", bus.weight, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
        chk("idle_in_ready", bus.in_ready, 0);
        chk("idle_w_rd_en", bus.w_rd_en, 0);
        chk("idle_w_addr", bus.w_addr, 0);
    endtask

    // Frame starts at cycle 0; each word takes 1 fetch + WORD_W stream cycles, plus stalls.
    task automatic run_frame(input logic [ADDR_W-1:0] base, input int stall_word, input int stall_len,
                             input int rst_bit, input bit poke);
        int wi = 0, left = stall_len, nbits = 0, nrd = 0, pk = -1;
        int done_exp = (WORD_W + 1) * N_WORDS + 1 + stall_len;
        bit aborted = 1'b0;
        for (int c = 0; c <= done_exp + 3; c++) begin
            bus.start    = (c == 0) || (poke && (c == 300 || c == done_exp));
            bus.w_base   = c == 0 ? base : ~base;
            bus.in_valid = (wi < N_WORDS) && !(wi == stall_word && left > 0);
            bus.in_data  = act[wi % N_WORDS];
            #1;
            if (pk >= 0) begin
                chk("weight", bus.weight, rom[ADDR_W'(base + pk / WORD_W)][pk % WORD_W]);
                pk = -1;
            end
            if (bus.ivalid) begin
                chk("inputdata", bus.inputdata, act[nbits / WORD_W][nbits % WORD_W]);
                pk = nbits;
                nbits++;
            end
            if (bus.w_rd_en) begin
                chk("w_addr", bus.w_addr, ADDR_W'(base + nrd));
                nrd++;
            end
            chk("busy", bus.busy, c >= 1 && c <= done_exp);
            chk("done", bus.done, c == done_exp);
            if (bus.in_ready && wi == stall_word && left > 0) begin
                chk("stall_ivalid", bus.ivalid, 0);
                chk("stall_w_rd_en", bus.w_rd_en, 0);
                left--;
            end
            if (bus.in_ready && bus.in_valid) wi++;
            if (rst_bit >= 0 && nbits == rst_bit + 1) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                bus.start = 1'b0;
                bus.in_valid = 1'b0;
                #1;
                chk_idle();
                aborted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!aborted) begin
            chk("ivalid_count", nbits, N_BITS);
            chk("rd_count", nrd, N_WORDS);
            chk("stall_cycles", left, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.w_base = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = WORD_W'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk_idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_WORDS; i++) begin act[i] = '1; rom[i] = '1; end
        run_frame('0, -1, 0, -1, 1'b0);
        for (int i = 0; i < N_WORDS; i++) act[i] = i == 0 ? WORD_W'(1) : '0;
        run_frame(ADDR_W'(200), -1, 0, -1, 1'b0);
        for (int i = 0; i < N_WORDS; i++) begin act[i] = WORD_W'($urandom); rom[72 + i] = '0; end
        rom[72] = 16'h8000;
        run_frame(ADDR_W'(72), -1, 0, -1, 1'b0);
        for (int i = 0; i < N_WORDS; i++) act[i] = WORD_W'($urandom);
        run_frame(ADDR_W'($urandom), 3, 5, -1, 1'b0);
        run_frame(ADDR_W'($urandom), -1, 0, 100, 1'b0);
        for (int i = 0; i < N_WORDS; i++) act[i] = WORD_W'($urandom);
        run_frame(ADDR_W'($urandom), -1, 0, -1, 1'b0);
        run_frame(ADDR_W'(1015), -1, 0, -1, 1'b1);
        for (int i = 0; i < N_WORDS; i++) act[i] = WORD_W'($urandom);
        run_frame(ADDR_W'($urandom), $urandom_range(N_WORDS - 1), $urandom_range(1, 9), -1, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
